// File: rtl/hazard_control_unit.sv
// hazard_control_unit
//   Stall/flush/forwarding controller for a 5-stage RV32 pipeline. One registered
//   FSM (IDLE / LOAD_WAIT / MD_BUSY) plus a small down-counter drives the IF/ID,
//   ID/EX and EX/MEM pipeline-register mux selects. The outputs are combinational
//   from the state and the current-cycle hazard inputs, so a hazard is stalled in
//   the same cycle it is seen. EX operand-forward selects are purely combinational.
//   Saturating performance counters track stall cycles and branch flushes.
// Ports
//   clk, rst                      clock, async active-high reset
//   rs1_id/rs2_id, rs*_valid_id   ID-stage sources and their use bits
//   rs1_ex/rs2_ex                 EX-stage sources (forwarding compare)
//   rd_*/we_*                     EX/MEM/WB destinations and write enables
//   load_ex/load_mem              load flags in EX and MEM
//   md_start_ex                   first-cycle pulse of a mul/div in EX
//   branch_taken                  EX redirect
//   cnt_clr                       synchronous perf counter clear
//   do_stall, mux_if_pm, mux_id_pm, ex_hold   pipeline control
//   fwd_a, fwd_b                  00 regfile, 01 MEM, 10 WB
//   stall_cnt, flush_cnt          saturating perf counters
module hazard_control_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic              rs1_valid_id,
  input  logic              rs2_valid_id,
  input  logic [REG_AW-1:0] rs1_ex,
  input  logic [REG_AW-1:0] rs2_ex,
  input  logic [REG_AW-1:0] rd_ex,
  input  logic              we_ex,
  input  logic              load_ex,
  input  logic              md_start_ex,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic              we_mem,
  input  logic              load_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              we_wb,
  input  logic              branch_taken,
  input  logic              cnt_clr,
  output logic              do_stall,
  output logic [1:0]        mux_if_pm,
  output logic [1:0]        mux_id_pm,
  output logic              ex_hold,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int MAXL = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LW   = 2'd1;
  localparam logic [1:0] S_MD   = 2'd2;

  localparam logic [1:0] PM_NORM = 2'b00;
  localparam logic [1:0] PM_NOP  = 2'b01;
  localparam logic [1:0] PM_FRZ  = 2'b10;

  // Reload values; the IDLE cycle that detects the event is itself the first
  // stall cycle, so LOAD_WAIT covers LOAD_LAT-1 more cycles and MD_BUSY covers
  // MD_LAT-2 more (mul/div freezes MD_LAT-1 cycles in total).
  localparam logic [CW-1:0] LW_RELOAD = CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
  localparam logic [CW-1:0] MD_RELOAD = CW'((MD_LAT > 2) ? MD_LAT - 3 : 0);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             stall, flush, hold;
  logic [1:0]       if_pm, id_pm;
  logic             hz_load, hz_raw;

  // x0 never matches; an unused source never matches.
  function automatic logic hit(input logic [REG_AW-1:0] src, input logic v,
                               input logic [REG_AW-1:0] rd, input logic we);
    return v & we & (rd != '0) & (src == rd);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
    if (hit(src, 1'b1, rd_mem, we_mem & ~load_mem)) return 2'b01;
    if (hit(src, 1'b1, rd_wb, we_wb))               return 2'b10;
    return 2'b00;
  endfunction

  assign hz_load = load_ex & (hit(rs1_id, rs1_valid_id, rd_ex, we_ex) |
                              hit(rs2_id, rs2_valid_id, rd_ex, we_ex));

  // Interlock mode: any in-flight producer in EX or MEM blocks the ID read.
  assign hz_raw = (FWD_EN == 0) &
                  (hit(rs1_id, rs1_valid_id, rd_ex,  we_ex)  |
                   hit(rs2_id, rs2_valid_id, rd_ex,  we_ex)  |
                   hit(rs1_id, rs1_valid_id, rd_mem, we_mem) |
                   hit(rs2_id, rs2_valid_id, rd_mem, we_mem));

  assign fwd_a = (FWD_EN != 0) ? fwd_sel(rs1_ex) : 2'b00;
  assign fwd_b = (FWD_EN != 0) ? fwd_sel(rs2_ex) : 2'b00;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if_pm   = PM_NORM;
    id_pm   = PM_NORM;
    hold    = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (branch_taken) begin
          if_pm = PM_NOP;
          id_pm = PM_NOP;
          flush = 1'b1;
        end else if (md_start_ex && (MD_LAT > 1)) begin
          if_pm = PM_FRZ;
          id_pm = PM_FRZ;
          hold  = 1'b1;
          stall = 1'b1;
          if (MD_LAT > 2) begin
            state_d = S_MD;
            cnt_d   = MD_RELOAD;
          end
        end else if (hz_load || hz_raw) begin
          if_pm = PM_FRZ;
          id_pm = PM_NOP;
          stall = 1'b1;
          if (LOAD_LAT > 1) begin
            state_d = S_LW;
            cnt_d   = LW_RELOAD;
          end
        end
      end
      S_LW: begin
        if (branch_taken) begin
          if_pm   = PM_NOP;
          id_pm   = PM_NOP;
          flush   = 1'b1;
          state_d = S_IDLE;
        end else begin
          if_pm = PM_FRZ;
          id_pm = PM_NOP;
          stall = 1'b1;
          if (cnt_q == '0) state_d = S_IDLE;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_MD: begin
        // Branches and hazards wait until the mul/div releases EX.
        if_pm = PM_FRZ;
        id_pm = PM_FRZ;
        hold  = 1'b1;
        stall = 1'b1;
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (cnt_clr) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Held in reset the pipeline sees plain pass-through, whatever the inputs say.
  assign do_stall  = stall & ~rst;
  assign ex_hold   = hold & ~rst;
  assign mux_if_pm = rst ? PM_NORM : if_pm;
  assign mux_id_pm = rst ? PM_NORM : id_pm;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
